mulacc_pipe: RTL and testbench

- Parametrised, pipelined N x N multiplier with an optional accumulator and a valid/ready stream handshake on input and output.
- Successor to the fixed 8-bit registered signed multiplier. Adds:
  - configurable width and pipeline depth
  - a per-transaction signed/unsigned select
  - multiply-accumulate mode
  - backpressure
- Sits in the arithmetic library as the standard registered multiply/MAC datapath for DSP-style consumers.

---
 rtl/arith_pkg.sv | 25 ++
 rtl/pipe_stage.sv | 39 +++
 rtl/mulacc_pipe.sv | 133 +++++++++++++
 tb/tb_mulacc_pipe.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic helpers: product-width helper and the result extension function
// used by the multiply and MAC datapaths.
package arith_pkg;

  // Widest product/result any client may request from ext().
  localparam int unsigned ExtMaxW = 128;

  function automatic int unsigned prod_w(input int unsigned n);
    return 2 * n;
  endfunction

  // Extends the low pw bits of p to ExtMaxW bits; callers truncate to their result width.
  function automatic logic [ExtMaxW-1:0] ext(input logic [ExtMaxW-1:0] p,
                                             input int unsigned      pw,
                                             input logic             is_signed);
    logic [ExtMaxW-1:0] r;
    logic               fill;
    fill = is_signed & p[pw-1];
    for (int unsigned i = 0; i < ExtMaxW; i++) begin
      r[i] = (i < pw) ? p[i] : fill;
    end
    return r;
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One pipeline register slot: valid bit plus W-bit payload, advancing when en_i is high.
module pipe_stage #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (en_i) begin
      valid_d = valid_i;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/mulacc_pipe.sv
// Pipelined N x N signed/unsigned multiplier with optional M-bit accumulator and
// valid/ready handshakes. rst is expected to deassert synchronously to clk upstream.
module mulacc_pipe
  import arith_pkg::*;
#(
  parameter int unsigned N      = 8,
  parameter int unsigned M      = 16,
  parameter int unsigned STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         is_signed,
  input  logic         acc_en,
  input  logic         acc_clr,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] c
);

  localparam int unsigned PW  = prod_w(N);
  localparam int unsigned OpW = 2 * N + 3;
  localparam int unsigned PdW = M + 2;
  localparam int unsigned NP  = (STAGES > 1) ? STAGES - 1 : 1;

  logic         stall, adv, in_fire;
  logic         out_valid_q, out_valid_d;
  logic [M-1:0] c_q, c_d;
  logic [M-1:0] acc_q, acc_d;

  // A held output freezes the whole pipe; stages never compress around bubbles.
  assign stall    = out_valid_q & ~out_ready;
  assign adv      = ~stall;
  assign in_ready = adv;
  assign in_fire  = in_valid & in_ready;

  logic           mul_v;
  logic [OpW-1:0] mul_op;

  if (STAGES == 1) begin : g_direct
    assign mul_v  = in_fire;
    assign mul_op = {a, b, is_signed, acc_en, acc_clr};
  end else begin : g_stage1
    pipe_stage #(
      .W(OpW)
    ) u_stage1 (
      .clk    (clk),
      .rst    (rst),
      .en_i   (adv),
      .valid_i(in_fire),
      .data_i ({a, b, is_signed, acc_en, acc_clr}),
      .valid_o(mul_v),
      .data_o (mul_op)
    );
  end

  logic [N-1:0]  mul_a, mul_b;
  logic          mul_sgn, mul_en, mul_clr;
  logic [PW-1:0] ax, bx, prod;
  logic [M-1:0]  p_ext;

  assign {mul_a, mul_b, mul_sgn, mul_en, mul_clr} = mul_op;

  // Low 2N bits of the 2N x 2N product are the same for signed and unsigned once the
  // operands are extended accordingly, so one multiplier covers both.
  assign ax    = {{N{mul_sgn & mul_a[N-1]}}, mul_a};
  assign bx    = {{N{mul_sgn & mul_b[N-1]}}, mul_b};
  assign prod  = ax * bx;
  assign p_ext = M'(ext(ExtMaxW'(prod), PW, mul_sgn));

  logic [NP-1:0]          pv;
  logic [NP-1:0][PdW-1:0] pd;

  assign pv[0] = mul_v;
  assign pd[0] = {p_ext, mul_en, mul_clr};

  for (genvar i = 1; i < int'(NP); i++) begin : g_pipe
    pipe_stage #(
      .W(PdW)
    ) u_stage (
      .clk    (clk),
      .rst    (rst),
      .en_i   (adv),
      .valid_i(pv[i-1]),
      .data_i (pd[i-1]),
      .valid_o(pv[i]),
      .data_o (pd[i])
    );
  end

  logic         fin_v, fin_en, fin_clr;
  logic [M-1:0] fin_p, acc_sum, res;

  assign fin_v                     = pv[NP-1];
  assign {fin_p, fin_en, fin_clr}  = pd[NP-1];
  assign acc_sum                   = acc_q + fin_p;
  assign res                       = (fin_en & ~fin_clr) ? acc_sum : fin_p;

  // Accumulator moves only on the edge a valid transaction enters the output register.
  always_comb begin
    out_valid_d = out_valid_q;
    c_d         = c_q;
    acc_d       = acc_q;
    if (adv) begin
      out_valid_d = fin_v;
      if (fin_v) begin
        c_d = res;
        if (fin_en) begin
          acc_d = res;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      c_q         <= '0;
      acc_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      c_q         <= c_d;
      acc_q       <= acc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign c         = c_q;

endmodule

// File: tb/tb_mulacc_pipe.sv
// Scoreboard bench for mulacc_pipe: three instances (8x8->16 S=2, 8x8->8 S=2, 8x8->16 S=4).
module tb_mulacc_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       in_valid[3], in_ready[3], sgn[3], en[3], clr[3], out_valid[3], out_ready[3];
  logic [7:0] a[3], b[3];
  logic [15:0] c0, c2;
  logic [7:0]  c1;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] c;
    bit          lat;
    int          due;
  } exp_t;

  exp_t q0[$], q1[$], q2[$];
  int n_chk = 0;
  int n_fail = 0;

  mulacc_pipe #(.N(8), .M(16), .STAGES(2)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .a(a[0]), .b(b[0]),
    .is_signed(sgn[0]), .acc_en(en[0]), .acc_clr(clr[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .c(c0)
  );

  mulacc_pipe #(.N(8), .M(8), .STAGES(2)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .a(a[1]), .b(b[1]),
    .is_signed(sgn[1]), .acc_en(en[1]), .acc_clr(clr[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .c(c1)
  );

  mulacc_pipe #(.N(8), .M(16), .STAGES(4)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .a(a[2]), .b(b[2]),
    .is_signed(sgn[2]), .acc_en(en[2]), .acc_clr(clr[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .c(c2)
  );

  function automatic int stg(input int d);
    return (d == 2) ? 4 : 2;
  endfunction

  function automatic logic [15:0] cval(input int d);
    case (d)
      0:       return c0;
      1:       return {8'h00, c1};
      default: return c2;
    endcase
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: pops the next expected result whenever an output transfer is about to occur.
  task automatic handle(input int d);
    exp_t e;
    bit   ok;
    ok = 1'b1;
    case (d)
      0: if (q0.size() == 0) ok = 1'b0; else e = q0.pop_front();
      1: if (q1.size() == 0) ok = 1'b0; else e = q1.pop_front();
      default: if (q2.size() == 0) ok = 1'b0; else e = q2.pop_front();
    endcase
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL unexpected_output dut%0d: got c=%h, expected no output", d, cval(d));
    end else begin
      check($sformatf("c_dut%0d", d), cval(d), e.c);
      if (e.lat) check_int($sformatf("latency_dut%0d", d), cyc, e.due);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 3; d++) begin
        if (out_valid[d] && out_ready[d]) handle(d);
      end
    end
  end

  task automatic send(input int d, input logic [7:0] av, input logic [7:0] bv, input logic s,
                      input logic e, input logic cl, input logic [15:0] ex, input bit lat,
                      input bit push);
    exp_t x;
    int   guard;
    in_valid[d] = 1'b1;
    a[d] = av;
    b[d] = bv;
    sgn[d] = s;
    en[d] = e;
    clr[d] = cl;
    guard = 0;
    @(negedge clk);
    while (!in_ready[d] && guard < 50) begin
      guard++;
      @(negedge clk);
    end
    if (guard >= 50) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout dut%0d: in_ready=%b, expected 1", d, in_ready[d]);
    end else if (push) begin
      x.c = ex;
      x.lat = lat;
      x.due = cyc + stg(d);
      case (d)
        0: q0.push_back(x);
        1: q1.push_back(x);
        default: q2.push_back(x);
      endcase
    end
    @(posedge clk);
    #1;
    in_valid[d] = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (q0.size() + q1.size() + q2.size()) != 0; i++) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      in_valid[d] = 1'b0;
      a[d] = '0;
      b[d] = '0;
      sgn[d] = 1'b0;
      en[d] = 1'b0;
      clr[d] = 1'b0;
      out_ready[d] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_out_valid_dut%0d", d), out_valid[d], 0);
      check($sformatf("rst_c_dut%0d", d), cval(d), 0);
      check($sformatf("rst_in_ready_dut%0d", d), in_ready[d], 1);
    end
    rst = 1'b0;
    idle();

    // Mid-stream reset on the 4-stage instance; first leave a nonzero c and accumulator.
    send(2, 8'd1, 8'd1, 1'b0, 1'b1, 1'b1, 16'd1, 1'b1, 1'b1);
    drain();
    send(2, 8'd7, 8'd7, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0);
    send(2, 8'd3, 8'd3, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0);
    send(2, 8'd5, 8'd5, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid[2], 0);
    check("midrst_c", c2, 0);
    check("midrst_in_ready", in_ready[2], 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
    send(2, 8'd2, 8'd3, 1'b0, 1'b1, 1'b0, 16'd6, 1'b1, 1'b1);

    // Bubbles: alternate valid/invalid slots, accumulator continues from 6.
    idle();
    send(2, 8'd1, 8'd1, 1'b0, 1'b1, 1'b0, 16'd7, 1'b1, 1'b1);
    idle();
    send(2, 8'd2, 8'd3, 1'b0, 1'b1, 1'b0, 16'd13, 1'b1, 1'b1);
    idle();
    send(2, 8'd1, 8'd5, 1'b0, 1'b0, 1'b0, 16'd5, 1'b1, 1'b1);
    idle();
    send(2, 8'd2, 8'd2, 1'b0, 1'b1, 1'b0, 16'd17, 1'b1, 1'b1);
    drain();

    // Signed/unsigned on the 16-bit result instance.
    send(0, 8'hFF, 8'h02, 1'b1, 1'b0, 1'b0, 16'hFFFE, 1'b1, 1'b1);
    send(0, 8'hFF, 8'h02, 1'b0, 1'b0, 1'b0, 16'h01FE, 1'b1, 1'b1);
    send(0, 8'h80, 8'h80, 1'b1, 1'b0, 1'b0, 16'h4000, 1'b1, 1'b1);

    // Accumulate chain, then a plain multiply that must leave the accumulator at 46.
    send(0, 8'd3, 8'd4, 1'b0, 1'b1, 1'b1, 16'd12, 1'b1, 1'b1);
    send(0, 8'd5, 8'd6, 1'b0, 1'b1, 1'b0, 16'd42, 1'b1, 1'b1);
    send(0, 8'd2, 8'd2, 1'b0, 1'b1, 1'b0, 16'd46, 1'b1, 1'b1);
    send(0, 8'd1, 8'd1, 1'b0, 1'b0, 1'b0, 16'd1, 1'b1, 1'b1);
    send(0, 8'd1, 8'd1, 1'b0, 1'b1, 1'b0, 16'd47, 1'b1, 1'b1);
    send(0, 8'hFF, 8'h01, 1'b1, 1'b1, 1'b0, 16'd46, 1'b1, 1'b1);
    drain();

    // Truncation and modular accumulation on the 8-bit result instance.
    send(1, 8'h10, 8'h11, 1'b0, 1'b0, 1'b0, 16'h0010, 1'b1, 1'b1);
    send(1, 8'hFF, 8'h02, 1'b1, 1'b0, 1'b0, 16'h00FE, 1'b1, 1'b1);
    send(1, 8'h0F, 8'h10, 1'b0, 1'b1, 1'b1, 16'h00F0, 1'b1, 1'b1);
    send(1, 8'h10, 8'h02, 1'b0, 1'b1, 1'b0, 16'h0010, 1'b1, 1'b1);
    drain();

    // Backpressure: four back-to-back MACs, output held for 3 cycles after the first result.
    fork
      begin
        send(0, 8'd1, 8'd2, 1'b0, 1'b1, 1'b1, 16'd2, 1'b0, 1'b1);
        send(0, 8'd3, 8'd3, 1'b0, 1'b1, 1'b0, 16'd11, 1'b0, 1'b1);
        send(0, 8'd2, 8'd5, 1'b0, 1'b1, 1'b0, 16'd21, 1'b0, 1'b1);
        send(0, 8'd4, 8'd4, 1'b0, 1'b1, 1'b0, 16'd37, 1'b0, 1'b1);
      end
      begin
        logic [15:0] hold;
        for (int i = 0; i < 20 && !out_valid[0]; i++) begin
          @(posedge clk);
          #1;
        end
        out_ready[0] = 1'b0;
        hold = c0;
        check("bp_first_value", hold, 16'd2);
        repeat (3) begin
          @(negedge clk);
          check("bp_in_ready_low", in_ready[0], 0);
          check("bp_out_valid_held", out_valid[0], 1);
          check("bp_c_stable", c0, hold);
        end
        @(posedge clk);
        #1;
        out_ready[0] = 1'b1;
      end
    join
    drain();

    check_int("q0_empty", q0.size(), 0);
    check_int("q1_empty", q1.size(), 0);
    check_int("q2_empty", q2.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
